// File: rtl/ram_reader.sv
// ram_reader
//   Streaming read engine for a synchronous-read single-port RAM. A start
//   command reads len_i consecutive words from base_addr_i. Addresses wrap at
//   MEM_DEPTH. The RAM's one-cycle read latency is absorbed by a 2-entry output
//   buffer, which feeds a valid/ready stream with a last marker.
//
// Ports
//   clk_i, rstn_i           clock, synchronous active-low reset
//   start_i                 command strobe (sampled only in IDLE)
//   base_addr_i, len_i      first word address, word count (clamped to MEM_DEPTH)
//   busy_o, done_o, err_o   status; done_o and err_o are one-cycle pulses
//   mem_rd_en_o, mem_addr_o RAM read request
//   mem_data_i              RAM data, valid the cycle after mem_rd_en_o
//   m_valid_o, m_ready_i,
//   m_data_o, m_last_o      output stream
module ram_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 66,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int LEN_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [LEN_WIDTH-1:0]  DEPTH_L   = LEN_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic                  rdv_q;     // RAM data for a previous request is on mem_data_i
  logic                  rdlast_q;  // ... and that request was the final one
  logic [1:0]            cnt_q;     // buffer occupancy
  logic [DATA_WIDTH-1:0] ent0_q, ent1_q;  // ent0 is the head
  logic                  last0_q, last1_q;
  logic                  done_q, err_q;

  logic pop, push, issue, issue_last;

  assign pop  = (cnt_q != 2'd0) && m_ready_i;
  assign push = rdv_q;

  // Credit: buffered + in-flight - popped must stay below 2. This is written as
  // an addition on both sides so it needs no signed arithmetic. The pop term
  // lets a read issue in the same cycle that ready returns.
  assign issue = (state_q == READ) && (issued_q < len_q) &&
                 (({1'b0, cnt_q} + {2'b0, rdv_q}) < (3'd2 + {2'b0, pop}));
  assign issue_last = issue && (issued_q == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      rdv_q    <= 1'b0;
      rdlast_q <= 1'b0;
      cnt_q    <= 2'd0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      last0_q  <= 1'b0;
      last1_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdv_q    <= issue;
      rdlast_q <= issue_last;

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if ({1'b0, base_addr_i} >= DEPTH_A) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q   <= base_addr_i;
              len_q    <= (len_i > DEPTH_L) ? DEPTH_L : len_i;
              issued_q <= '0;
              state_q  <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + LEN_WIDTH'(1);
            if (issue_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last0_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Two-entry shift buffer. The credit rule prevents a push while it is full.
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_q  <= mem_data_i;
            last0_q <= rdlast_q;
          end else begin
            ent1_q  <= mem_data_i;
            last1_q <= rdlast_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          last0_q <= last1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q  <= mem_data_i;
            last0_q <= rdlast_q;
          end else begin
            ent0_q  <= ent1_q;
            last0_q <= last1_q;
            ent1_q  <= mem_data_i;
            last1_q <= rdlast_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_rd_en_o = issue;
  assign mem_addr_o  = addr_q;
  assign m_valid_o   = (cnt_q != 2'd0);
  assign m_data_o    = ent0_q;
  // The head's last flag is stale once the buffer empties, so it is gated.
  assign m_last_o    = last0_q && m_valid_o;

endmodule

// File: tb/tb_ram_reader.sv
module tb_ram_reader;
  localparam int DW = 16, DEPTH = 66, AW = 7, LW = 7;

  logic          clk = 1'b0;
  logic          rstn, start, busy, done, err, rd_en, m_valid, m_ready, m_last;
  logic [AW-1:0] base, mem_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] mem_data, m_data;
  logic [DW-1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_reader #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_addr_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .mem_rd_en_o(rd_en),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  // Synchronous-read RAM model, word[i] = i
  always @(posedge clk) if (rd_en) mem_data <= ram[mem_addr];

  typedef struct {
    int base;
    int len;
    bit rnd;       // pseudo-random m_ready
    bit inj;       // extra start while busy
    bit exp_err;
    int exp_beats;
    int exp_done;  // cycle of done_o relative to start cycle, -1 = unchecked
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
    chk({name, " err"}, int'(err), 0);
    chk({name, " rd_en"}, int'(rd_en), 0);
    chk({name, " valid"}, int'(m_valid), 0);
    chk({name, " last"}, int'(m_last), 0);
    chk({name, " addr"}, int'(mem_addr), 0);
    chk({name, " data"}, int'(m_data), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int beats = 0, issues = 0, done_cyc = -1;
    bit err_seen = 0, ended = 0, pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0;
    @(negedge clk);
    start = 1'b1; base = AW'(v.base); len = LW'(v.len); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 3000; n++) begin
      m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.inj) begin
        start = (n == 2); base = AW'(30); len = LW'(5);
      end
      #1;
      if (pv && !pr) begin
        chk("stall valid", int'(m_valid), 1);
        chk("stall data", int'(m_data), int'(pd));
        chk("stall last", int'(m_last), int'(pl));
      end
      if (rd_en) begin
        chk("rd addr", int'(mem_addr), (v.base + issues) % DEPTH);
        issues++;
      end
      if (m_valid && m_ready) begin
        chk("beat data", int'(m_data), (v.base + beats) % DEPTH);
        chk("beat last", int'(m_last), int'(beats == v.exp_beats - 1));
        beats++;
      end
      if (issues - beats > 2) chk("occupancy", issues - beats, 2);
      if (err) begin
        err_seen = 1;
        chk("busy at err", int'(busy), 0);
      end
      if (done) begin
        done_cyc = n;
        chk("busy at done", int'(busy), 0);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (done || err) begin
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("ended", int'(ended), 1);
    chk("err pulse", int'(err_seen), int'(v.exp_err));
    chk("beats", beats, v.exp_beats);
    chk("reads", issues, v.exp_beats);
    if (v.exp_done >= 0) chk("done cycle", done_cyc, v.exp_done);
    @(negedge clk); #1;
    chk("pulse end", int'(done || err || busy), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    vecs[0] = '{0, 4, 0, 0, 0, 4, 7};     // basic
    vecs[1] = '{64, 4, 0, 0, 0, 4, 7};    // wrap 64,65,0,1
    vecs[2] = '{0, 8, 1, 0, 0, 8, -1};    // random backpressure
    vecs[3] = '{0, 0, 0, 0, 0, 0, 1};     // len 0
    vecs[4] = '{70, 3, 0, 0, 1, 0, -1};   // bad base
    vecs[5] = '{0, 4, 0, 1, 0, 4, 7};     // start while busy ignored
    vecs[6] = '{10, 3, 1, 0, 0, 3, -1};   // short, backpressure
    vecs[7] = '{0, 66, 0, 0, 0, 66, 69};  // full depth
    vecs[8] = '{60, 100, 0, 0, 0, 66, 69}; // clamped, wraps

    rstn = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset mid-transfer: beats 0,1 in cycles 3,4, reset sampled at end of cycle 5
    @(negedge clk);
    start = 1'b1; base = '0; len = LW'(10); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk_idle_outputs("midreset");
    rstn = 1'b1;
    run_vec('{5, 2, 0, 0, 0, 2, 5});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_reader.md
# ram_reader

Streaming read engine for the synchronous-read (block type) single-port RAM. On a start command it reads `len_i` consecutive words beginning at `base_addr_i`, absorbs the RAM's one-cycle read latency in a 2-entry output buffer, and presents the words as a valid/ready stream with a last marker. It is the read-side counterpart to the RAM write path, and it sits between the RAM port and any downstream stream consumer.

## Interface

Parameters:

- `DATA_WIDTH`, 16, RAM word width
- `MEM_DEPTH`, 66, number of RAM words
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`, RAM address width
- `LEN_WIDTH`, `$clog2(MEM_DEPTH+1)`, transfer length width (0..MEM_DEPTH)

Ports:

- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i` in 1: clock
- `rstn_i` in 1: synchronous active-low reset
- `start_i` in 1: command strobe, sampled only in IDLE
- `base_addr_i` in ADDR_WIDTH: first word address
- `len_i` in LEN_WIDTH: number of words to read
- `busy_o` out 1: transfer in progress
- `done_o` out 1: one-cycle pulse at transfer end
- `err_o` out 1: one-cycle pulse when a command is rejected
- `mem_rd_en_o` out 1: read request to RAM
- `mem_addr_o` out ADDR_WIDTH: RAM read address
- `mem_data_i` in DATA_WIDTH: RAM data, valid one cycle after `mem_rd_en_o`
- `m_valid_o` out 1: stream data valid
- `m_ready_i` in 1: stream consumer ready
- `m_data_o` out DATA_WIDTH: stream data
- `m_last_o` out 1: final beat of transfer

## Operation

- States:
  - IDLE: `busy_o`=0.
  - READ: issuing requests; `busy_o`=1.
  - DRAIN: all requests issued, buffer emptying; `busy_o`=1.
- IDLE handling of `start_i`:
  - `base_addr_i >= MEM_DEPTH`: command is rejected. `err_o` pulses next cycle and the state stays IDLE.
  - `len_i == 0`: `done_o` pulses next cycle and no beats are produced.
  - `len_i > MEM_DEPTH`: clamped to MEM_DEPTH.
  - Otherwise: latch base and length, then go to READ.
- `start_i` while busy is ignored.
- Address sequence: base, base+1, and so on. The address wraps from MEM_DEPTH-1 to 0; it does not wrap at 2^ADDR_WIDTH.
- Credit rule: issue a read when `issued < len` and `(buffer_count + inflight - pop) < 2`, where `pop` = `m_valid_o && m_ready_i` this cycle. The buffer never overflows.
- READ goes to DRAIN in the cycle after the last request issues.
- DRAIN goes to IDLE on the handshake of the beat with `m_last_o`=1. `done_o` pulses in the next cycle, and `busy_o` is 0 in that same cycle.
- Stream rules:
  - `m_data_o` and `m_last_o` stay stable while `m_valid_o && !m_ready_i`.
  - `m_valid_o` never drops without a handshake.
  - Words are delivered in address order with none lost or duplicated.
- Reset mid-transfer: next state is IDLE, the buffer is flushed, and in-flight RAM data is discarded.

## Timing

- Reset values: `busy_o`, `done_o`, `err_o`, `mem_rd_en_o`, `m_valid_o`, `m_last_o` = 0; `mem_addr_o`, `m_data_o` = 0.
- Start accepted in cycle 0:
  - `mem_rd_en_o`=1 with `mem_addr_o`=base in cycle 1.
  - `mem_data_i` valid in cycle 2.
  - `m_valid_o`=1 with word[base] in cycle 3, since the buffer output is registered.
- Throughput: with `m_ready_i` held high, one beat per cycle. `len` beats occupy cycles 3..len+2, and `done_o` pulses in cycle len+3.
- Backpressure: at most 2 reads are outstanding or buffered. With `m_ready_i` low, `mem_rd_en_o` stops after 2 requests. When ready returns, the first issue occurs in the same cycle as the pop.
- Next `start_i` is accepted in the cycle `done_o`=1 (state is IDLE).

## Test plan

- RAM preloaded with word[i]=i. Start base=0, len=4, `m_ready_i`=1 → beats 0,1,2,3 in cycles 3..6, `m_last_o` only on beat 3, `done_o` pulses in cycle 7.
- Wrap-around: MEM_DEPTH=66, base=64, len=4 → `mem_addr_o` sequence 64,65,0,1; data 64,65,0,1.
- Backpressure: len=8, `m_ready_i` toggled pseudo-randomly → 8 in-order beats; `mem_rd_en_o` count equals 8; buffer occupancy never exceeds 2; data is stable while stalled.
- Boundary commands:
  - len=0 → `done_o` pulse, no `m_valid_o`.
  - base=70 → `err_o` pulse, state stays IDLE.
  - `start_i` during a transfer → ignored, original transfer completes unchanged.
- Reset after the 2nd beat of len=10 → next cycle all outputs 0 and `busy_o`=0. A new start base=5, len=2 then yields exactly 5,6.
- Full-depth read: base=0, len=66 → 66 beats with one beat per cycle, `done_o` in cycle 69.
